// File: rtl/sound_pkg.sv
// Shared field positions, types and helpers for the sound request queue.
package sound_pkg;

  localparam int TOG_BIT  = 11;
  localparam int HOLD_MSB = 10;
  localparam int HOLD_LSB = 7;
  localparam int NOTE_MSB = 6;

  localparam logic [6:0] NOTE_SILENT = 7'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } sq_state_t;

  typedef struct packed {
    logic [3:0] hold;
    logic [6:0] note;
  } sq_entry_t;

  // A hold field of zero still plays for one unit.
  function automatic logic [3:0] eff_hold(input logic [3:0] h);
    return (h == 4'd0) ? 4'd1 : h;
  endfunction

endpackage

// File: rtl/sound_fifo.sv
// Synchronous DEPTH-entry request FIFO with flush; a push while full is only
// accepted when a pop happens in the same cycle.
module sound_fifo
  import sound_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  sq_entry_t     wr_data,
  output sq_entry_t     rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  sq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sound_queue.sv
// Sound request queue: detects toggled sound_sel requests, buffers them and
// plays each for hold*UNIT_TICKS ticks plus a silent gap. Option macro: SOUND_QUEUE_PRIORITY_EN.
module sound_queue
  import sound_pkg::*;
#(
  parameter int         DEPTH      = 8,
  parameter int         CLK_HZ     = 40000000,
  parameter int         TICK_HZ    = 1000,
  parameter int         UNIT_TICKS = 32,
  parameter int         GAP_TICKS  = 10,
  parameter logic [6:0] PRIO_BASE  = 7'd64
) (
  input  logic                         clk,
  input  logic                         reset_b,
  input  logic [11:0]                  sound_sel,
  input  logic                         clr_ovf,
  output logic [6:0]                   play_sel,
  output logic                         play_active,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DMAX = (15 * UNIT_TICKS > GAP_TICKS) ? 15 * UNIT_TICKS : GAP_TICKS;
  localparam int DW   = $clog2(DMAX + 1);

  function automatic logic [DW-1:0] play_ticks(input logic [3:0] h);
    return DW'(eff_hold(h)) * DW'(UNIT_TICKS);
  endfunction

  logic [11:0]   s1_q, s2_q, s3_q;
  logic [2:0]    fill_q;
  logic          armed_q, last_tog_q;
  sq_state_t     state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [6:0]    play_sel_q, play_sel_d;
  logic          play_active_q, play_active_d;
  logic          overflow_q;

  logic          w_stable, w_new, w_prio, w_push, w_pop, w_tick;
  logic          w_full, w_empty;
  sq_entry_t     w_req, w_head;

  // s3 only holds a genuine input sample once the pipe has filled after reset.
  assign w_stable = fill_q[2] && (s2_q == s3_q);
  assign w_new    = armed_q && w_stable && (s3_q[TOG_BIT] != last_tog_q);
  assign w_req    = '{hold: s3_q[HOLD_MSB:HOLD_LSB], note: s3_q[NOTE_MSB:0]};

`ifdef SOUND_QUEUE_PRIORITY_EN
  assign w_prio = w_new && (w_req.note >= PRIO_BASE);
`else
  logic unused_prio;
  assign w_prio      = 1'b0;
  assign unused_prio = ^PRIO_BASE;
`endif

  assign w_push = w_new && !w_prio;
  assign w_tick = (pre_q == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      fill_q     <= '0;
      armed_q    <= 1'b0;
      last_tog_q <= 1'b0;
    end else begin
      s1_q   <= sound_sel;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
      if (!armed_q && w_stable) begin
        armed_q    <= 1'b1;
        last_tog_q <= s3_q[TOG_BIT];
      end else if (w_new) begin
        last_tog_q <= s3_q[TOG_BIT];
      end
    end
  end

  sound_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (w_push),
    .pop     (w_pop),
    .flush   (w_prio),
    .wr_data (w_req),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    dur_d         = dur_q;
    pre_d         = w_tick ? '0 : pre_q + PW'(1);
    play_sel_d    = play_sel_q;
    play_active_d = play_active_q;
    w_pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        pre_d = '0;
        if (!w_empty) begin
          w_pop         = 1'b1;
          state_d       = PLAY;
          dur_d         = play_ticks(w_head.hold);
          play_sel_d    = w_head.note;
          play_active_d = 1'b1;
        end
      end
      PLAY: begin
        if (w_tick) begin
          if (dur_q <= DW'(1)) begin
            state_d       = GAP;
            dur_d         = DW'(GAP_TICKS);
            play_sel_d    = NOTE_SILENT;
            play_active_d = 1'b0;
          end else begin
            dur_d = dur_q - DW'(1);
          end
        end
      end
      GAP: begin
        if (w_tick) begin
          if (dur_q <= DW'(1)) begin
            if (!w_empty) begin
              w_pop         = 1'b1;
              state_d       = PLAY;
              dur_d         = play_ticks(w_head.hold);
              play_sel_d    = w_head.note;
              play_active_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dur_d = dur_q - DW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A priority capture overrides whatever the FSM was doing.
    if (w_prio) begin
      w_pop         = 1'b0;
      state_d       = PLAY;
      dur_d         = play_ticks(w_req.hold);
      play_sel_d    = w_req.note;
      play_active_d = 1'b1;
      pre_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q       <= IDLE;
      dur_q         <= '0;
      pre_q         <= '0;
      play_sel_q    <= NOTE_SILENT;
      play_active_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dur_q         <= dur_d;
      pre_q         <= pre_d;
      play_sel_q    <= play_sel_d;
      play_active_q <= play_active_d;
      if (w_push && w_full && !w_pop) overflow_q <= 1'b1;
      else if (clr_ovf)               overflow_q <= 1'b0;
    end
  end

  assign play_sel    = play_sel_q;
  assign play_active = play_active_q;
  assign overflow    = overflow_q;

endmodule
